// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin scheduler sharing one start/done GCD engine among N_REQ requesters
// Optional WAIT timeout enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*W-1:0]       req_a,
   input  logic [N_REQ*W-1:0]       req_b,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         resp_valid,
   output logic [W-1:0]             resp_data,
   output logic [$clog2(N_REQ)-1:0] resp_id,
   output logic                     resp_err,
   output logic                     eng_start,
   output logic [W-1:0]             eng_a,
   output logic [W-1:0]             eng_b,
   input  logic                     eng_done,
   input  logic [W-1:0]             eng_result
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  sel;
   logic [IW-1:0]  pick;
   logic [IW-1:0]  idx;
   logic           found;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;

`ifdef GCD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0]  wait_cnt;
`endif

   // First pending requester at or after ptr, searching modulo N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % N_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel == IW'(i)) begin
            sel_a = req_a[i*W +: W];
            sel_b = req_b[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ptr        <= '0;
         sel        <= '0;
         gnt        <= '0;
         resp_valid <= '0;
         resp_id    <= '0;
         resp_data  <= '0;
         eng_start  <= 1'b0;
         eng_a      <= '0;
         eng_b      <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
         resp_err   <= 1'b0;
         wait_cnt   <= '0;
`endif
      end else begin
         gnt        <= '0;
         resp_valid <= '0;
         eng_start  <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
         resp_err   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (found) begin
                  sel   <= pick;
                  gnt   <= ONE << pick;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               eng_a <= sel_a;
               eng_b <= sel_b;
               ptr   <= (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
               // The subtraction engine never terminates on a zero operand.
               if (sel_a == '0 || sel_b == '0) begin
                  resp_data  <= sel_a | sel_b;
                  resp_valid <= ONE << sel;
                  resp_id    <= sel;
                  state      <= S_RESP;
               end else begin
                  eng_start <= 1'b1;
                  state     <= S_START;
               end
            end
            S_START: begin
`ifdef GCD_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_done) begin
                  resp_data  <= eng_result;
                  resp_valid <= ONE << sel;
                  resp_id    <= sel;
                  state      <= S_RESP;
               end
`ifdef GCD_ARB_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) begin
                  resp_data  <= '0;
                  resp_err   <= 1'b1;
                  resp_valid <= ONE << sel;
                  resp_id    <= sel;
                  state      <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef GCD_ARB_TIMEOUT_EN
   // Constant 0; TIMEOUT has no effect in this build.
   assign resp_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - directed self-checking bench for gcd_arbiter
module tb_gcd_arbiter;

   localparam int N_REQ   = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [31:0]  req_a;
   logic [31:0]  req_b;
   logic [3:0]   gnt;
   logic [3:0]   resp_valid;
   logic [7:0]   resp_data;
   logic [1:0]   resp_id;
   logic         resp_err;
   logic         eng_start;
   logic [7:0]   eng_a;
   logic [7:0]   eng_b;
   logic         eng_done;
   logic [7:0]   eng_result;

   int n_cmp = 0;
   int n_err = 0;

   gcd_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .gnt        (gnt),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_err   (resp_err),
      .eng_start  (eng_start),
      .eng_a      (eng_a),
      .eng_b      (eng_b),
      .eng_done   (eng_done),
      .eng_result (eng_result)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      eng_done = 1'b0;
      eng_result = '0;
      tick;
      tick;
      n_cmp++;
      if ({gnt, resp_valid, resp_data, resp_id, resp_err, eng_start} !== 18'h0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %h expected 0", {gnt, resp_valid, resp_data, resp_id, resp_err, eng_start});
      end
      n_cmp++;
      if ({eng_a, eng_b} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_operands: got %h expected 0", {eng_a, eng_b});
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_single;
      req_a[7:0] = 8'd48;
      req_b[7:0] = 8'd18;
      req_valid = 4'b0001;
      tick;
      n_cmp++;
      if (gnt !== 4'b0001 || eng_start !== 1'b0) begin
         n_err++;
         $display("FAIL single_gnt: got gnt=%b start=%b expected gnt=0001 start=0", gnt, eng_start);
      end
      req_valid = '0;
      tick;
      n_cmp++;
      if (eng_start !== 1'b1 || gnt !== 4'b0000) begin
         n_err++;
         $display("FAIL single_start: got start=%b gnt=%b expected start=1 gnt=0000", eng_start, gnt);
      end
      n_cmp++;
      if ({eng_a, eng_b} !== {8'd48, 8'd18}) begin
         n_err++;
         $display("FAIL single_operands: got a=%0d b=%0d expected a=48 b=18", eng_a, eng_b);
      end
      tick;
      tick;
      n_cmp++;
      if (eng_start !== 1'b0 || resp_valid !== 4'b0000) begin
         n_err++;
         $display("FAIL single_wait: got start=%b resp_valid=%b expected 0 and 0000", eng_start, resp_valid);
      end
      eng_done = 1'b1;
      eng_result = 8'd6;
      tick;
      eng_done = 1'b0;
      n_cmp++;
      if (resp_valid !== 4'b0001 || resp_data !== 8'd6 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
         n_err++;
         $display("FAIL single_resp: got v=%b d=%0d id=%0d err=%b expected v=0001 d=6 id=0 err=0",
                  resp_valid, resp_data, resp_id, resp_err);
      end
      tick;
      n_cmp++;
      if (resp_valid !== 4'b0000) begin
         n_err++;
         $display("FAIL single_resp_pulse: got %b expected 0000", resp_valid);
      end
   endtask

   task automatic test_zero_bypass;
      logic [7:0] exp_b [2];
      exp_b[0] = 8'd35;
      exp_b[1] = 8'd0;
      for (int i = 0; i < 2; i++) begin
         req_a[23:16] = 8'd0;
         req_b[23:16] = exp_b[i];
         req_valid = 4'b0100;
         tick;
         n_cmp++;
         if (gnt !== 4'b0100 || eng_start !== 1'b0) begin
            n_err++;
            $display("FAIL zero_gnt_%0d: got gnt=%b start=%b expected gnt=0100 start=0", i, gnt, eng_start);
         end
         req_valid = '0;
         tick;
         n_cmp++;
         if (resp_valid !== 4'b0100 || resp_data !== exp_b[i] || resp_id !== 2'd2 || eng_start !== 1'b0) begin
            n_err++;
            $display("FAIL zero_resp_%0d: got v=%b d=%0d id=%0d start=%b expected v=0100 d=%0d id=2 start=0",
                     i, resp_valid, resp_data, resp_id, eng_start, exp_b[i]);
         end
         tick;
      end
   endtask

   task automatic test_round_robin;
      int exp_order [10];
      logic [3:0] exp_g;
      int cyc;
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3};
      rst = 1'b1;
      req_a = '0;
      req_b = {8'd4, 8'd3, 8'd2, 8'd1};
      req_valid = 4'b1111;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp_g = 4'(1) << exp_order[i];
         cyc = 0;
         tick;
         while (gnt === 4'b0000 && cyc < 8) begin
            tick;
            cyc++;
         end
         n_cmp++;
         if (gnt !== exp_g) begin
            n_err++;
            $display("FAIL rr_gnt_%0d: got %b expected %b", i, gnt, exp_g);
         end
         if (i == 7) req_valid = 4'b1010;
         tick;
         n_cmp++;
         if (resp_valid !== exp_g || resp_data !== 8'(exp_order[i] + 1) || resp_id !== 2'(exp_order[i])) begin
            n_err++;
            $display("FAIL rr_resp_%0d: got v=%b d=%0d id=%0d expected v=%b d=%0d id=%0d",
                     i, resp_valid, resp_data, resp_id, exp_g, exp_order[i] + 1, exp_order[i]);
         end
      end
      req_valid = '0;
      tick;
      tick;
   endtask

   task automatic test_mid_reset;
      logic seen;
      req_a[15:8] = 8'd12;
      req_b[15:8] = 8'd8;
      req_valid = 4'b0010;
      tick;
      n_cmp++;
      if (gnt !== 4'b0010) begin
         n_err++;
         $display("FAIL mrst_gnt: got %b expected 0010", gnt);
      end
      req_valid = '0;
      tick;
      tick;
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({gnt, resp_valid, resp_data, resp_id, resp_err, eng_start, eng_a, eng_b} !== 34'h0) begin
         n_err++;
         $display("FAIL mrst_outputs: got %h expected 0",
                  {gnt, resp_valid, resp_data, resp_id, resp_err, eng_start, eng_a, eng_b});
      end
      tick;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (resp_valid !== 4'b0000 || gnt !== 4'b0000 || eng_start !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL mrst_quiet: got activity=%b expected 0", seen);
      end
      req_a = '0;
      req_b = {8'd4, 8'd3, 8'd2, 8'd1};
      req_valid = 4'b1111;
      tick;
      n_cmp++;
      if (gnt !== 4'b0001) begin
         n_err++;
         $display("FAIL mrst_ptr: got %b expected 0001", gnt);
      end
      req_valid = '0;
      tick;
      n_cmp++;
      if (resp_valid !== 4'b0001 || resp_data !== 8'd1) begin
         n_err++;
         $display("FAIL mrst_resp: got v=%b d=%0d expected v=0001 d=1", resp_valid, resp_data);
      end
      tick;
   endtask

   task automatic test_stray_done;
      eng_done = 1'b1;
      eng_result = 8'd99;
      tick;
      eng_done = 1'b0;
      tick;
      n_cmp++;
      if (resp_valid !== 4'b0000 || gnt !== 4'b0000 || eng_start !== 1'b0) begin
         n_err++;
         $display("FAIL stray_idle: got v=%b gnt=%b start=%b expected all 0", resp_valid, gnt, eng_start);
      end
      req_a[31:24] = 8'd9;
      req_b[31:24] = 8'd6;
      req_valid = 4'b1000;
      tick;
      req_valid = '0;
      tick;
      n_cmp++;
      if (eng_start !== 1'b1) begin
         n_err++;
         $display("FAIL stray_start: got %b expected 1", eng_start);
      end
      eng_done = 1'b1;
      eng_result = 8'd77;
      tick;
      eng_done = 1'b0;
      n_cmp++;
      if (resp_valid !== 4'b0000) begin
         n_err++;
         $display("FAIL stray_in_start: got %b expected 0000", resp_valid);
      end
      tick;
      eng_done = 1'b1;
      eng_result = 8'd3;
      tick;
      eng_done = 1'b0;
      n_cmp++;
      if (resp_valid !== 4'b1000 || resp_data !== 8'd3 || resp_id !== 2'd3) begin
         n_err++;
         $display("FAIL stray_resp: got v=%b d=%0d id=%0d expected v=1000 d=3 id=3", resp_valid, resp_data, resp_id);
      end
      tick;
   endtask

   task automatic test_wait_limit;
      logic early;
      req_a[15:8] = 8'd10;
      req_b[15:8] = 8'd4;
      req_valid = 4'b0010;
      tick;
      req_valid = '0;
      tick;
      early = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      for (int i = 0; i < TIMEOUT; i++) begin
         tick;
         if (resp_valid !== 4'b0000) early = 1'b1;
      end
      n_cmp++;
      if (early !== 1'b0) begin
         n_err++;
         $display("FAIL to_early: got early=%b expected 0", early);
      end
      tick;
      n_cmp++;
      if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_data !== 8'd0) begin
         n_err++;
         $display("FAIL to_resp: got v=%b err=%b d=%0d expected v=0010 err=1 d=0", resp_valid, resp_err, resp_data);
      end
      tick;
      req_valid = 4'b0010;
      tick;
      req_valid = '0;
      tick;
      tick;
`else
      for (int i = 0; i < 3 * TIMEOUT; i++) begin
         tick;
         if (resp_valid !== 4'b0000) early = 1'b1;
      end
      n_cmp++;
      if (early !== 1'b0) begin
         n_err++;
         $display("FAIL wait_hold: got early=%b expected 0", early);
      end
`endif
      eng_done = 1'b1;
      eng_result = 8'd2;
      tick;
      eng_done = 1'b0;
      n_cmp++;
      if (resp_valid !== 4'b0010 || resp_err !== 1'b0 || resp_data !== 8'd2) begin
         n_err++;
         $display("FAIL wait_done: got v=%b err=%b d=%0d expected v=0010 err=0 d=2", resp_valid, resp_err, resp_data);
      end
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_single;
      test_zero_bypass;
      test_round_robin;
      test_mid_reset;
      test_stray_done;
      test_wait_limit;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin scheduler sharing one subtraction-based GCD engine among N_REQ requesters. Grants one request at a time, hands its operands to the engine with a start pulse, waits for the done pulse and returns the result to the granted requester tagged with its index. Zero operands are resolved locally, because the subtraction engine never terminates on them. Sits between requester blocks and a single `gcd`-style engine that has a start/done handshake.

## Interface
- N_REQ, 4: number of requesters; 2..8.
- W, 8: operand and result width.
- TIMEOUT, 1023: WAIT-cycle limit. Used only with the timeout macro.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  request level per requester.
- req_a  in  N_REQ*W  operand a; slice i = bits [i*W +: W].
- req_b  in  N_REQ*W  operand b; same slicing.
- gnt  out  N_REQ  one-hot, one-cycle grant.
- resp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- resp_data  out  W  GCD result; valid while resp_valid is nonzero.
- resp_id  out  $clog2(N_REQ)  index of the responding requester.
- resp_err  out  1  timeout flag; qualified by resp_valid.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a, eng_b  out  W  engine operands; stable from START until the end of WAIT.
- eng_done  in  1  engine completion pulse.
- eng_result  in  W  engine result; sampled when eng_done=1.

## Operation
- States: IDLE, ISSUE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first requester at or after ptr, searching modulo N_REQ. Latch its index as sel, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - gnt[sel]=1 for this one cycle.
  - req_a/req_b slice sel is latched into eng_a/eng_b at the closing edge.
  - ptr <= (sel+1) mod N_REQ.
  - If either operand is 0: latch result = a|b (gcd(0,0)=0) and go to RESP, bypassing the engine.
  - Otherwise go to START.
- START: eng_start=1 for one cycle, then go to WAIT.
- WAIT:
  - Hold until eng_done=1.
  - On eng_done, latch eng_result and go to RESP.
- RESP:
  - resp_valid[sel]=1, resp_id=sel, resp_data=latched result, resp_err=0 (except on timeout, see Configuration).
  - Always returns to IDLE.
- Handshake:
  - A requester holds req_valid and its operands stable until it sees gnt[i].
  - It may deassert req_valid, or present a new request, from the cycle after gnt.
  - A request raised before the previous response arrives is queued naturally by the level protocol and served in rotation.
- eng_done outside WAIT is ignored.
- req_valid changes outside IDLE have no effect until the next IDLE.
- Reset (asynchronous, at any time, including mid-operation):
  - state=IDLE, ptr=0, sel=0.
  - gnt, resp_valid, resp_id, resp_data, resp_err, eng_start, eng_a, eng_b all 0.
  - An in-flight request is dropped with no response. The engine must share rst.

## Timing
- req_valid[i] high in cycle t, with the arbiter in IDLE:
  - gnt[i]=1 in cycle t+1.
  - eng_start=1 in cycle t+2.
- Engine raises eng_done in cycle d: resp_valid[i]=1 in cycle d+1.
- Zero-operand bypass: resp_valid in cycle t+2; eng_start never asserted.
- Minimum gap between responses: one IDLE cycle, so throughput is at most one request per 4+engine cycles.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Configuration
- GCD_ARB_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without eng_done: go to RESP with resp_err=1 and resp_data=0.
  - If eng_done arrives in the same cycle the limit is hit, eng_done wins and resp_err=0.
  - Counter width is $clog2(TIMEOUT+1).
- Not defined: no counter; WAIT persists until eng_done; resp_err is tied to 0.

## Test plan
- Reset then single request: req 0 with a=48, b=18 at t. Expect gnt[0] at t+1, eng_start at t+2, resp_valid[0] with resp_data=6 and resp_id=0 one cycle after eng_done.
- Zero bypass: req 2 with a=0, b=35. Expect resp_data=35 at t+2 with no eng_start. Then a=0, b=0: expect resp_data=0.
- Round robin: all four requesters held high from reset. Expect grant order 0,1,2,3,0. After serving 3 with only reqs 1 and 3 pending, expect grant order 1 then 3.
- Mid-operation reset: assert rst during WAIT. Expect all outputs 0 immediately, no resp_valid, and the next grant goes to req 0 despite the previous ptr.
- Stray eng_done pulsed in IDLE and START: expect no state change and no response.
- With GCD_ARB_TIMEOUT_EN and TIMEOUT=16, engine never completes: expect resp_valid with resp_err=1 and resp_data=0 exactly 16 WAIT cycles after START. Then a normal request completes with resp_err=0.
